// File: rtl/spi_slave.sv
// SPI mode-0 slave in the clk domain: synchronizes SCLK/CS/MOSI, assembles
// received bytes and shifts out a single-entry buffered transmit byte.
module spi_slave #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              CS,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              rx_overrun,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_e;

   state_e            state_q, state_d;

   logic              sclk_s1_q, sclk_s2_q, sclk_h_q;
   logic              cs_s1_q, cs_s2_q, cs_h_q;
   logic              mosi_s1_q, mosi_s2_q;

   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              tx_full_q, tx_full_d;
   logic              rx_valid_q, rx_valid_d;
   logic              byte_done_q, byte_done_d;
   logic              miso_q, miso_d;
   logic              overrun_q, overrun_d;
   logic              frame_err_q, frame_err_d;

   logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic              buf_read;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] buf_out;

   assign sclk_rise = sclk_s2_q & ~sclk_h_q;
   assign sclk_fall = ~sclk_s2_q & sclk_h_q;
   assign cs_fall   = ~cs_s2_q & cs_h_q;
   assign cs_rise   = cs_s2_q & ~cs_h_q;

   assign rx_shift  = (rx_sr_q << 1) | DATA_W'(mosi_s2_q);
   assign buf_out   = tx_full_q ? tx_buf_q : '0;

   always_comb begin
      // NOTE: every signal gets a default before the branches, so no path
      // leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      tx_buf_d    = tx_buf_q;
      tx_full_d   = tx_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      byte_done_d = byte_done_q;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      buf_read    = 1'b0;

      if (rx_ack) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d     = ACTIVE;
               buf_read    = 1'b1;
               tx_sr_d     = buf_out;
               bit_cnt_d   = '0;
               byte_done_d = 1'b0;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d     = IDLE;
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               rx_sr_d     = '0;
               byte_done_d = 1'b0;
            end else if (sclk_rise) begin
               rx_sr_d = rx_shift;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d   = '0;
                  rx_data_d   = rx_shift;
                  rx_valid_d  = 1'b1;
                  overrun_d   = rx_valid_q & ~rx_ack;
                  byte_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (sclk_fall) begin
               // The fall after a completed byte starts the next byte of the frame.
               if (byte_done_q) begin
                  buf_read    = 1'b1;
                  tx_sr_d     = buf_out;
                  byte_done_d = 1'b0;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
               end
            end
         end
      endcase

      // A read empties the buffer first; a same-cycle load then refills it.
      if (buf_read) begin
         tx_full_d = 1'b0;
      end
      if (tx_load && !tx_full_q) begin
         tx_buf_d  = tx_data;
         tx_full_d = 1'b1;
      end

      miso_d = (state_d == ACTIVE) ? tx_sr_d[DATA_W-1] : 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (rst) begin
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_h_q    <= 1'b0;
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         cs_h_q      <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         tx_buf_q    <= '0;
         tx_full_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         byte_done_q <= 1'b0;
         miso_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_s1_q   <= SCLK;
         sclk_s2_q   <= sclk_s1_q;
         sclk_h_q    <= sclk_s2_q;
         cs_s1_q     <= CS;
         cs_s2_q     <= cs_s1_q;
         cs_h_q      <= cs_s2_q;
         mosi_s1_q   <= MOSI;
         mosi_s2_q   <= mosi_s1_q;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         tx_buf_q    <= tx_buf_d;
         tx_full_q   <= tx_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         byte_done_q <= byte_done_d;
         miso_q      <= miso_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign MISO       = miso_q;
   assign tx_ready   = ~tx_full_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_overrun = overrun_q;
   assign frame_err  = frame_err_q;
   assign busy       = ~cs_s2_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per SPI byte (transfers are MSB first).
REQ-002 SHALL have port clk  input  1  system clock; every flop is on its rising edge; the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port SCLK  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL have port CS  input  1  chip select from master, active-low, asynchronous.
REQ-006 SHALL have port MOSI  input  1  serial data from master.
REQ-007 SHALL have port MISO  output  1  serial data to master, registered.
REQ-008 SHALL have port tx_data  input  DATA_W  byte offered for the next transfer.
REQ-009 SHALL have port tx_load  input  1  write strobe for tx_data; accepted only while tx_ready=1.
REQ-010 SHALL have port tx_ready  output  1  level; tx buffer is empty.
REQ-011 SHALL have port rx_data  output  DATA_W  last complete byte received.
REQ-012 SHALL have port rx_valid  output  1  level; rx_data is unread.
REQ-013 SHALL have port rx_ack  input  1  one-cycle strobe; consumer has read rx_data.
REQ-014 SHALL have port rx_overrun  output  1  one-cycle pulse; an unread byte was overwritten.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse; CS rose mid-byte.
REQ-016 SHALL have port busy  output  1  level; synchronized CS is low.

Function
REQ-017 SHALL pass SCLK, CS and MOSI through two-flop synchronizers plus one history flop; edges are detected on the synchronized signals only.
REQ-018 SHALL implement SPI mode 0: sample MOSI on each SCLK rising edge; update MISO on each SCLK falling edge.
REQ-019 SHALL support SCLK high and low phases of at least 4 clk periods each, and a CS-fall-to-first-SCLK-rise interval of at least 4 clk periods.
REQ-020 SHALL use a two-state FSM:
  - IDLE -> ACTIVE on synchronized CS fall.
  - ACTIVE -> IDLE on synchronized CS rise.
REQ-021 On IDLE->ACTIVE, SHALL load the tx shift register with the tx buffer if it is full, else all zeros; the buffer is then empty (tx_ready=1).
REQ-022 SHALL drive MISO from the tx shift register MSB while ACTIVE, and 0 while IDLE.
REQ-023 On each synchronized SCLK rise in ACTIVE, SHALL shift MOSI into the rx shift register LSB and increment the bit counter (0..DATA_W-1).
REQ-024 On the rise that captures bit DATA_W-1, at the same clk edge, SHALL:
  - write the assembled byte to rx_data;
  - set rx_valid;
  - clear the bit counter.
  This is the second clk edge after the first synchronizer flop samples SCLK high.
REQ-025 On each synchronized SCLK fall in ACTIVE, SHALL shift the tx register left, except after a completed byte. In that case it SHALL reload from the tx buffer, or zeros if the buffer is empty, for back-to-back bytes within one CS frame.
REQ-026 rx_valid SHALL clear on rx_ack; if rx_ack and a byte completion coincide, rx_valid SHALL stay 1 with the new byte and no overrun is flagged.
REQ-027 If a byte completes while rx_valid=1 and rx_ack=0, SHALL overwrite rx_data and pulse rx_overrun for one cycle.
REQ-028 tx_load while tx_ready=1 SHALL capture tx_data and clear tx_ready next cycle; tx_load while tx_ready=0 SHALL be ignored.
REQ-029 If tx_load coincides with a buffer read at frame start or at a byte reload, the read SHALL take the old buffer contents first, and the new tx_data SHALL be stored (tx_ready stays 0).
REQ-030 If CS rises with the bit counter non-zero, SHALL pulse frame_err for one cycle, discard the partial byte, clear the counter and leave rx_valid/rx_data unchanged.
REQ-031 SCLK edges while IDLE SHALL be ignored.

Reset
REQ-032 On rst=1 at a clk edge, SHALL set:
  - FSM=IDLE, MISO=0, tx_ready=1, rx_data=0, rx_valid=0;
  - rx_overrun=0, frame_err=0, busy=0;
  - bit counter=0, both shift registers=0, synchronizers to idle levels (CS=1, SCLK=0).
REQ-033 rst mid-transfer SHALL abort without a frame_err pulse; the tx buffer contents SHALL be discarded.

Verification
REQ-034 Reset: assert rst 3 cycles during an active frame -> all outputs at REQ-032 values, no rx_valid or frame_err.
REQ-035 Basic: tx_load 0xC5, master sends 0xE2 (SCLK period 8 clk) -> rx_data=0xE2, rx_valid=1 two clk edges after the 8th SCLK rise is first sampled; master receives 0xC5; tx_ready=1.
REQ-036 Empty tx: no tx_load, master sends 0x83 -> MISO stays 0 for all 8 bits; rx_data=0x83.
REQ-037 Back-to-back: one CS frame, master sends 0x11 then 0x22, no rx_ack -> rx_overrun pulses once, rx_data=0x22, rx_valid=1.
REQ-038 Abort: CS rises after 5 SCLK rises -> frame_err pulses once, rx_valid unchanged; next frame sending 0xA5 -> rx_data=0xA5.
REQ-039 Coincidence: rx_ack on the same cycle a byte completes -> rx_valid remains 1, no rx_overrun.
